multi_channel_deglitch: RTL and testbench

//  NUM_CH-wide deglitch filter for slow external inputs: GPIO, buttons, card-detect, PMU status.

---
 rtl/deglitch_pkg.sv | 11 +
 rtl/deglitch_channel.sv | 94 +++++++++
 rtl/multi_channel_deglitch.sv | 42 ++++
 tb/tb_multi_channel_deglitch.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/deglitch_pkg.sv
// Shared types for the multi-channel deglitch filter.
// Per-channel output bundle: filtered level plus edge events.
package deglitch_pkg;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
    } dg_ev_t;

endpackage

// File: rtl/deglitch_channel.sv
// One deglitch channel: optional synchroniser, saturating
// up/down counter with hysteresis, registered level and edges.
module deglitch_channel
    import deglitch_pkg::*;
#(
    parameter int   CNT_W       = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             d_i,
    output dg_ev_t           ev_o
);

    typedef logic [CNT_W-1:0] dg_cnt_t;

    localparam dg_cnt_t CNT_RST = {CNT_W{RESET_VAL}};

    logic    s;
    dg_cnt_t cnt_q, cnt_d;
    logic    q_q, q_d;
    logic    rise_q, fall_q;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // Synchroniser chain, free-running regardless of en_i.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync_q <= {SYNC_STAGES{RESET_VAL}};
            end else begin
                sync_q[0] <= d_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign s = d_i;
    end

    // Counter step and hysteretic level decision.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (!en_i) begin
            cnt_d = cnt_q;
        end else if (thresh_i == '0) begin
            cnt_d = '0;
            q_d   = s;
        end else begin
            priority case (1'b1)
                (cnt_q > thresh_i):
                    cnt_d = thresh_i;
                (s && (cnt_q < thresh_i)):
                    cnt_d = cnt_q + 1'b1;
                (!s && (cnt_q != '0)):
                    cnt_d = cnt_q - 1'b1;
                default:
                    cnt_d = cnt_q;
            endcase
            if (cnt_d == thresh_i) begin
                q_d = 1'b1;
            end else if (cnt_d == '0) begin
                q_d = 1'b0;
            end
        end
    end

    // Counter, level and edge-pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= CNT_RST;
            q_q    <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= q_d & ~q_q;
            fall_q <= ~q_d & q_q;
        end
    end

    assign ev_o.q    = q_q;
    assign ev_o.rise = rise_q;
    assign ev_o.fall = fall_q;

endmodule

// File: rtl/multi_channel_deglitch.sv
// NUM_CH independent deglitch channels sharing one
// run-time threshold.
module multi_channel_deglitch
    import deglitch_pkg::*;
#(
    parameter int   NUM_CH      = 8,
    parameter int   CNT_W       = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic [CNT_W-1:0]  thresh_i,
    input  logic [NUM_CH-1:0] d_i,
    output logic [NUM_CH-1:0] q_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dg_ev_t ev;

        deglitch_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (RESET_VAL)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (en_i[c]),
            .thresh_i (thresh_i),
            .d_i      (d_i[c]),
            .ev_o     (ev)
        );

        assign q_o[c]    = ev.q;
        assign rise_o[c] = ev.rise;
        assign fall_o[c] = ev.fall;
    end

endmodule

// File: tb/tb_multi_channel_deglitch.sv
// Directed bench for multi_channel_deglitch: one RESET_VAL=0
// instance for filtering, one RESET_VAL=1 instance for reset.
module tb_multi_channel_deglitch;

    logic       clk;
    logic       rst, rst1;
    logic [7:0] en, en1;
    logic [3:0] thr, thr1;
    logic [7:0] d, d1;
    logic [7:0] q, rise, fall;
    logic [7:0] q1, rise1, fall1;

    int total = 0;
    int bad   = 0;

    multi_channel_deglitch #(
        .NUM_CH(8), .CNT_W(4), .SYNC_STAGES(2), .RESET_VAL(1'b0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .thresh_i(thr),
        .d_i(d), .q_o(q), .rise_o(rise), .fall_o(fall)
    );

    multi_channel_deglitch #(
        .NUM_CH(8), .CNT_W(4), .SYNC_STAGES(2), .RESET_VAL(1'b1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .en_i(en1), .thresh_i(thr1),
        .d_i(d1), .q_o(q1), .rise_o(rise1), .fall_o(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic seen;
    int   rises2;

    initial begin
        rst = 1'b1; en = 8'hff; thr = 4'd4; d = 8'h00;
        rst1 = 1'b1; en1 = 8'hff; thr1 = 4'd4; d1 = 8'hff;
        tick(2);
        check("rst_q", q, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst1_q", q1, 8'hff);
        rst = 1'b0; rst1 = 1'b0;
        tick(3);
        check("idle_q", q, 0);
        check("idle1_q", q1, 8'hff);
        check("idle1_pulse", rise1 | fall1, 0);

        // ch0 rise latency SYNC+T = 6
        d[0] = 1'b1;
        tick(5);
        check("t1_q_early", q[0], 0);
        tick(1);
        check("t1_q", q[0], 1);
        check("t1_rise", rise[0], 1);
        tick(1);
        check("t1_rise_end", rise[0], 0);
        check("t1_q_hold", q[0], 1);

        // ch1 3-cycle glitch must be rejected
        d[1] = 1'b1;
        tick(3);
        d[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen |= q[1] | rise[1] | fall[1];
        end
        check("t2_glitch", seen, 0);
        d[1] = 1'b1;
        tick(5);
        check("t2_q_early", q[1], 0);
        tick(1);
        check("t2_q", q[1], 1);

        // ch2 duty 2/3 at T=3; ch0/ch1 clamp to 3 without fall
        thr = 4'd3;
        seen = 1'b0;
        rises2 = 0;
        for (int i = 0; i < 18; i++) begin
            d[2] = (i % 3) != 2;
            tick(1);
            seen |= |fall[2:0];
            if (rise[2]) rises2++;
        end
        check("t3_q", q[2:0], 3'b111);
        check("t3_nofall", seen, 0);
        check("t3_rises", rises2, 1);
        d[2] = 1'b1;

        // ch4 count=10 at T=15, then lower T to 5
        thr = 4'd15;
        d[4] = 1'b1;
        tick(12);
        check("t4_q_pre", q[4], 0);
        thr = 4'd5;
        tick(1);
        check("t4_q_clamp", q[4], 1);
        check("t4_rise", rise[4], 1);
        thr = 4'd0;
        d[4] = 1'b0;
        tick(2);
        check("t4_byp_q1", q[4], 1);
        tick(1);
        check("t4_byp_q0", q[4], 0);
        check("t4_byp_fall", fall[4], 1);
        d[4] = 1'b1;
        tick(3);
        check("t4_byp_rise", {q[4], rise[4]}, 2'b11);

        // ch3 frozen while disabled, then 1-of-4 enable
        thr = 4'd4;
        tick(1);
        en[3] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d[3] = ~d[3];
            tick(1);
            seen |= q[3] | rise[3] | fall[3];
        end
        check("t5_frozen", seen, 0);
        d[3] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            en[3] = (k % 4) == 0;
            tick(1);
            if (k == 15) check("t5_q_early", q[3], 0);
            if (k == 16) check("t5_q", {q[3], rise[3]}, 2'b11);
        end
        en[3] = 1'b1;

        // RESET_VAL=1: reset mid-count, then clamp to T
        d1[0] = 1'b0;
        tick(4);
        check("t6_q_mid", q1[0], 1);
        check("t6_nofall_mid", fall1[0], 0);
        rst1 = 1'b1;
        d1[0] = 1'b1;
        tick(1);
        check("t6_rst_q", q1[0], 1);
        check("t6_rst_pulse", {rise1[0], fall1[0]}, 0);
        rst1 = 1'b0;
        tick(1);
        check("t6_clamp_q", q1[0], 1);
        check("t6_clamp_pulse", {rise1[0], fall1[0]}, 0);
        d1[0] = 1'b0;
        tick(5);
        check("t6_fall_early", q1[0], 1);
        tick(1);
        check("t6_fall_q", q1[0], 0);
        check("t6_fall", fall1[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
